// File: rtl/fpu_fp80_to_fpn_pipe.sv
// FP80 extended -> IEEE binary(EXP_W, FRAC_W) converter, two-stage valid/ready pipeline.
// Define FPU_CVT_DENORM_OUT_EN for gradual underflow; otherwise tiny results flush to zero.
module fpu_fp80_to_fpn_pipe #(
  parameter int unsigned EXP_W  = 8,
  parameter int unsigned FRAC_W = 23
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [79:0]             fp80_in,
  input  logic [1:0]              rc_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXP_W+FRAC_W:0]   fp_out,
  output logic [3:0]              flags_out
);

  localparam int unsigned OutW = 1 + EXP_W + FRAC_W;
  localparam int unsigned SigW = 1 + FRAC_W;
  localparam int Bias = (1 << (EXP_W - 1)) - 1;
  localparam logic signed [16:0] BiasS   = 17'(Bias);
  localparam logic signed [16:0] MinUe   = 17'(1 - Bias);
  localparam logic signed [16:0] ShMaxS  = 17'(FRAC_W + 2);
  localparam logic [EXP_W-1:0]   ExpOnes = '1;
  localparam logic [EXP_W-1:0]   ExpMaxFin = ExpOnes - 1'b1;
  localparam logic [FRAC_W-1:0]  QnanFrac = FRAC_W'(64'h1 << (FRAC_W - 1));
  localparam logic [FRAC_W-1:0]  FracOnes = '1;

  typedef enum logic [1:0] {
    RcNear  = 2'b00,
    RcDown  = 2'b01,
    RcUp    = 2'b10,
    RcTrunc = 2'b11
  } rc_e;

  // Stage 1: unpack and classify
  logic               in_sign;
  logic [14:0]        in_exp;
  logic [63:0]        in_man;
  logic [FRAC_W-1:0]  nan_frac;
  logic               spec_hit, spec_inv, in_tiny;
  logic [OutW-1:0]    spec_res;
  logic signed [16:0] in_ue, sh_full;
  logic [6:0]         in_sh;

  assign in_sign  = fp80_in[79];
  assign in_exp   = fp80_in[78:64];
  assign in_man   = fp80_in[63:0];
  // Quieted NaN payload: forced quiet bit, then the top payload bits below m[62].
  assign nan_frac = FRAC_W'({1'b1, in_man[61:0]} >> (63 - FRAC_W));

  always_comb begin
    spec_hit = 1'b1;
    spec_inv = 1'b0;
    spec_res = '0;
    in_ue    = $signed({2'b00, in_exp}) - 17'sd16383;
    if (in_exp == 15'h0) begin
      in_ue = -17'sd16382;
    end
    in_tiny = (in_ue < MinUe);
    sh_full = MinUe - in_ue;
    in_sh   = 7'd0;
    if (in_tiny) begin
      in_sh = (sh_full > ShMaxS) ? ShMaxS[6:0] : sh_full[6:0];
    end

    if (in_exp == 15'h7fff) begin
      if (!in_man[63]) begin
        spec_res = {1'b1, ExpOnes, QnanFrac};
        spec_inv = 1'b1;
      end else if (in_man[62:0] == 63'h0) begin
        spec_res = {in_sign, ExpOnes, {FRAC_W{1'b0}}};
      end else begin
        spec_res = {in_sign, ExpOnes, nan_frac};
        spec_inv = !in_man[62];
      end
    end else if (in_exp != 15'h0 && !in_man[63]) begin
      spec_res = {1'b1, ExpOnes, QnanFrac};
      spec_inv = 1'b1;
    end else if (in_exp == 15'h0 && in_man == 64'h0) begin
      spec_res = {in_sign, {(OutW-1){1'b0}}};
    end else begin
      spec_hit = 1'b0;
    end
  end

  logic               s1_valid_q, s1_special_q, s1_spec_inv_q, s1_sign_q, s1_tiny_q;
  logic [OutW-1:0]    s1_spec_res_q;
  rc_e                s1_rc_q;
  logic signed [16:0] s1_ue_q;
  logic [6:0]         s1_sh_q;
  logic [63:0]        s1_man_q;

  // Stage 2: align, round, pack
  logic [127:0]      ext, rest;
  logic [SigW-1:0]   sig;
  logic              guard, sticky, inexact, rnd_inc, to_inf;
  logic [SigW:0]     rounded;
  logic signed [16:0] ue_r;
  logic [EXP_W-1:0]  exp_b;
  logic [OutW-1:0]   res_d;
  logic [3:0]        flags_d;

  always_comb begin
    ext     = {s1_man_q, 64'h0} >> s1_sh_q;
    sig     = ext[127 -: SigW];
    guard   = ext[127 - SigW];
    rest    = ext << (SigW + 1);
    sticky  = |rest;
    inexact = guard | sticky;
    case (s1_rc_q)
      RcNear:  rnd_inc = guard & (sticky | sig[0]);
      RcDown:  rnd_inc = s1_sign_q & inexact;
      RcUp:    rnd_inc = !s1_sign_q & inexact;
      RcTrunc: rnd_inc = 1'b0;
      default: rnd_inc = 1'b0;
    endcase
    rounded = {1'b0, sig} + {{SigW{1'b0}}, rnd_inc};
    ue_r    = s1_ue_q + $signed({16'h0, rounded[SigW]});
    exp_b   = EXP_W'(ue_r + BiasS);
    to_inf  = (s1_rc_q == RcNear) || (s1_rc_q == RcUp && !s1_sign_q) ||
              (s1_rc_q == RcDown && s1_sign_q);

    res_d   = '0;
    flags_d = '0;
    if (s1_special_q) begin
      res_d   = s1_spec_res_q;
      flags_d = {s1_spec_inv_q, 3'b000};
    end else if (s1_tiny_q) begin
`ifdef FPU_CVT_DENORM_OUT_EN
      // Aligned significand has no hidden bit; a carry into bit FRAC_W lands on exp=1.
      res_d   = {s1_sign_q, (EXP_W-1)'(0), rounded[FRAC_W:0]};
      flags_d = {2'b00, inexact, inexact};
`else
      res_d   = {s1_sign_q, EXP_W'(0),
                 FRAC_W'((s1_rc_q == RcUp && !s1_sign_q) || (s1_rc_q == RcDown && s1_sign_q))};
      flags_d = 4'b0011;
`endif
    end else if (ue_r > BiasS) begin
      res_d   = to_inf ? {s1_sign_q, ExpOnes, {FRAC_W{1'b0}}} : {s1_sign_q, ExpMaxFin, FracOnes};
      flags_d = 4'b0101;
    end else begin
      // On carry the rounded significand is 10..0, so its low bits are already zero.
      res_d   = {s1_sign_q, exp_b, rounded[FRAC_W-1:0]};
      flags_d = {3'b000, inexact};
    end
  end

  logic                s2_valid_q, s2_adv;
  logic [OutW-1:0]     fp_q;
  logic [3:0]          flags_q;

  assign s2_adv    = !s2_valid_q || out_ready;
  assign in_ready  = !s1_valid_q || s2_adv;
  assign out_valid = s2_valid_q;
  assign fp_out    = fp_q;
  assign flags_out = flags_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q    <= 1'b0;
      s1_special_q  <= 1'b0;
      s1_spec_inv_q <= 1'b0;
      s1_spec_res_q <= '0;
      s1_sign_q     <= 1'b0;
      s1_tiny_q     <= 1'b0;
      s1_rc_q       <= RcNear;
      s1_ue_q       <= '0;
      s1_sh_q       <= '0;
      s1_man_q      <= '0;
      s2_valid_q    <= 1'b0;
      fp_q          <= '0;
      flags_q       <= '0;
    end else begin
      if (in_ready) begin
        s1_valid_q <= in_valid;
        if (in_valid) begin
          s1_special_q  <= spec_hit;
          s1_spec_inv_q <= spec_inv;
          s1_spec_res_q <= spec_res;
          s1_sign_q     <= in_sign;
          s1_tiny_q     <= in_tiny;
          s1_rc_q       <= rc_e'(rc_in);
          s1_ue_q       <= in_ue;
          s1_sh_q       <= in_sh;
          s1_man_q      <= in_man;
        end
      end
      if (s2_adv) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          fp_q    <= res_d;
          flags_q <= flags_d;
        end
      end
    end
  end

endmodule

// File: tb/tb_fpu_fp80_to_fpn_pipe.sv
// Scoreboard bench for fpu_fp80_to_fpn_pipe: FP32 instance for most vectors, FP64 instance
// for a few wide-format vectors.
`timescale 1ns/1ps
module tb_fpu_fp80_to_fpn_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [79:0] fp80_in;
  logic [1:0]  rc_in;
  logic [31:0] fp_out;
  logic [3:0]  flags_out;

  logic        d_in_valid, d_in_ready, d_out_valid, d_out_ready;
  logic [79:0] d_fp80_in;
  logic [1:0]  d_rc_in;
  logic [63:0] d_fp_out;
  logic [3:0]  d_flags_out;

  fpu_fp80_to_fpn_pipe #(.EXP_W(8), .FRAC_W(23)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .fp80_in(fp80_in), .rc_in(rc_in), .out_valid(out_valid), .out_ready(out_ready),
    .fp_out(fp_out), .flags_out(flags_out)
  );

  fpu_fp80_to_fpn_pipe #(.EXP_W(11), .FRAC_W(52)) dut64 (
    .clk(clk), .reset(reset), .in_valid(d_in_valid), .in_ready(d_in_ready),
    .fp80_in(d_fp80_in), .rc_in(d_rc_in), .out_valid(d_out_valid), .out_ready(d_out_ready),
    .fp_out(d_fp_out), .flags_out(d_flags_out)
  );

  typedef struct packed {
    logic [79:0] fp80;
    logic [1:0]  rc;
    logic [31:0] res;
    logic [3:0]  flg;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs [NV];

  int tests = 0;
  int fails = 0;
  logic [35:0] exp_q[$];
  int          id_q[$];
  logic [67:0] d_exp_q[$];
  int          rdy_mode = 0;  // 0: always ready, 1: toggle, 2: never ready

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1:       out_ready = ~out_ready;
        2:       out_ready = 1'b0;
        default: out_ready = 1'b1;
      endcase
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
    tests++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  // FP32 monitor: pops on every accepted output, checks hold-stability while stalled.
  logic        held;
  logic [35:0] held_val;
  logic [35:0] e;
  int          eid;
  initial begin
    held = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        held = 1'b0;
      end else begin
        if (held) begin
          tests++;
          if (!out_valid || {fp_out, flags_out} !== held_val) begin
            fails++;
            $display("FAIL stall_hold: got valid=%0b %h/%b, required valid=1 %h/%b",
                     out_valid, fp_out, flags_out, held_val[35:4], held_val[3:0]);
          end
        end
        held = 1'b0;
        if (out_valid && out_ready) begin
          tests++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_output: got %h/%b, required no output", fp_out, flags_out);
          end else begin
            e   = exp_q.pop_front();
            eid = id_q.pop_front();
            if ({fp_out, flags_out} !== e) begin
              fails++;
              $display("FAIL vec%0d: got %h flags %b, required %h flags %b",
                       eid, fp_out, flags_out, e[35:4], e[3:0]);
            end
          end
        end else if (out_valid) begin
          held     = 1'b1;
          held_val = {fp_out, flags_out};
        end
      end
    end
  end

  logic [67:0] de;
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && d_out_valid && d_out_ready) begin
        tests++;
        if (d_exp_q.size() == 0) begin
          fails++;
          $display("FAIL fp64_unexpected: got %h/%b, required no output", d_fp_out, d_flags_out);
        end else begin
          de = d_exp_q.pop_front();
          if ({d_fp_out, d_flags_out} !== de) begin
            fails++;
            $display("FAIL fp64: got %h flags %b, required %h flags %b",
                     d_fp_out, d_flags_out, de[67:4], de[3:0]);
          end
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge with in_valid still high.
  task automatic send(input int id);
    int n = 0;
    in_valid = 1'b1;
    fp80_in  = vecs[id].fp80;
    rc_in    = vecs[id].rc;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      in_valid = 1'b0;
      $display("FAIL accept_timeout vec%0d: in_ready got 0, required 1", id);
    end else begin
      exp_q.push_back({vecs[id].res, vecs[id].flg});
      id_q.push_back(id);
    end
    @(negedge clk);
  endtask

  task automatic send64(input logic [79:0] x, input logic [1:0] rc, input logic [67:0] ex);
    int n = 0;
    d_in_valid = 1'b1;
    d_fp80_in  = x;
    d_rc_in    = rc;
    while (!d_in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!d_in_ready) begin
      tests++;
      fails++;
      d_in_valid = 1'b0;
      $display("FAIL fp64_accept_timeout: in_ready got 0, required 1");
    end else begin
      d_exp_q.push_back(ex);
    end
    @(negedge clk);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || d_exp_q.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(name, 64'(exp_q.size() + d_exp_q.size()), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = {80'h3FFF_8000000000000000, 2'd0, 32'h3F800000, 4'b0000};
    vecs[1]  = {80'h3FFF_8000008000000000, 2'd0, 32'h3F800000, 4'b0001};
    vecs[2]  = {80'h3FFF_8000008000000000, 2'd2, 32'h3F800001, 4'b0001};
    vecs[3]  = {80'h407F_8000000000000000, 2'd0, 32'h7F800000, 4'b0101};
    vecs[4]  = {80'h407F_8000000000000000, 2'd3, 32'h7F7FFFFF, 4'b0101};
    vecs[5]  = {80'h7FFF_A000000000000000, 2'd0, 32'h7FE00000, 4'b1000};
    vecs[6]  = {80'h4001_4000000000000000, 2'd0, 32'hFFC00000, 4'b1000};
`ifdef FPU_CVT_DENORM_OUT_EN
    vecs[7]  = {80'h3F80_8000000000000000, 2'd0, 32'h00400000, 4'b0000};
    vecs[19] = {80'h3F80_FFFFFFFFFFFFFFFF, 2'd0, 32'h00800000, 4'b0011};
`else
    vecs[7]  = {80'h3F80_8000000000000000, 2'd0, 32'h00000000, 4'b0011};
    vecs[19] = {80'h3F80_FFFFFFFFFFFFFFFF, 2'd0, 32'h00000000, 4'b0011};
`endif
    vecs[8]  = {80'hBFFF_C000000000000000, 2'd0, 32'hBFC00000, 4'b0000};
    vecs[9]  = {80'hFFFF_8000000000000000, 2'd0, 32'hFF800000, 4'b0000};
    vecs[10] = {80'h7FFF_C000000000000001, 2'd0, 32'h7FC00000, 4'b0000};
    vecs[11] = {80'h8000_0000000000000000, 2'd0, 32'h80000000, 4'b0000};
    vecs[12] = {80'hC07F_8000000000000000, 2'd1, 32'hFF800000, 4'b0101};
    vecs[13] = {80'hC07F_8000000000000000, 2'd2, 32'hFF7FFFFF, 4'b0101};
    vecs[14] = {80'h3FFF_FFFFFFFFFFFFFFFF, 2'd0, 32'h40000000, 4'b0001};
    vecs[15] = {80'h3FFF_FFFFFFFFFFFFFFFF, 2'd3, 32'h3FFFFFFF, 4'b0001};
    vecs[16] = {80'h407E_FFFFFFFFFFFFFFFF, 2'd0, 32'h7F800000, 4'b0101};
    vecs[17] = {80'h0000_0000000000000001, 2'd2, 32'h00000001, 4'b0011};
    vecs[18] = {80'h0000_0000000000000001, 2'd0, 32'h00000000, 4'b0011};
    vecs[20] = {80'h7FFF_0000000000000000, 2'd0, 32'hFFC00000, 4'b1000};
    vecs[21] = {80'h3FFF_8000008000000000, 2'd1, 32'h3F800000, 4'b0001};
    vecs[22] = {80'h8000_0000000000000001, 2'd1, 32'h80000001, 4'b0011};
    vecs[23] = {80'h407E_FFFFFF0000000000, 2'd0, 32'h7F7FFFFF, 4'b0000};

    reset       = 1'b1;
    in_valid    = 1'b0;
    fp80_in     = '0;
    rc_in       = '0;
    d_in_valid  = 1'b0;
    d_fp80_in   = '0;
    d_rc_in     = '0;
    d_out_ready = 1'b1;

    repeat (3) @(negedge clk);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_fp_out", 64'(fp_out), 64'd0);
    chk("reset_flags", 64'(flags_out), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("in_ready_after_reset", 64'(in_ready), 64'd1);

    // Latency: one edge after accept nothing yet, two edges after accept the result is out.
    send(0);
    in_valid = 1'b0;
    chk("latency_edge1", 64'(out_valid), 64'd0);
    @(negedge clk);
    chk("latency_edge2", 64'(out_valid), 64'd1);
    drain("drain_latency");

    for (int i = 0; i < NV; i++) send(i);
    in_valid = 1'b0;
    drain("drain_full_rate");

    rdy_mode = 1;
    for (int i = 0; i < 8; i++) send(i + 1);
    in_valid = 1'b0;
    drain("drain_toggle");
    rdy_mode = 0;

    // Fill both stages under backpressure, then reset drops them.
    rdy_mode = 2;
    @(negedge clk);
    send(3);
    send(5);
    in_valid = 1'b0;
    chk("full_in_ready", 64'(in_ready), 64'd0);
    chk("full_out_valid", 64'(out_valid), 64'd1);
    reset = 1'b1;
    exp_q.delete();
    id_q.delete();
    @(negedge clk);
    chk("midreset_out_valid", 64'(out_valid), 64'd0);
    reset    = 1'b0;
    rdy_mode = 0;
    repeat (4) @(negedge clk);
    chk("after_reset_no_output", 64'(out_valid), 64'd0);

    send64(80'h3FFF_8000000000000000, 2'd0, {64'h3FF0000000000000, 4'b0000});
    send64(80'h3FFF_8000000000000800, 2'd0, {64'h3FF0000000000001, 4'b0000});
    send64(80'h3FFF_8000000000000400, 2'd0, {64'h3FF0000000000000, 4'b0001});
    send64(80'h43FF_8000000000000000, 2'd3, {64'h7FEFFFFFFFFFFFFF, 4'b0101});
    d_in_valid = 1'b0;
    drain("drain_fp64");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
